// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared constants and state encoding for the register dump unit
// Purpose: FSM state encoding, first dumped index and the regfile geometry
// defaults shared with the processor's register file.
package regfile_dump_pkg;

  localparam int NREGS_DEF = 32;
  localparam int WIDTH_DEF = 32;
  localparam int IDX_W_DEF = 5;

  // r0 is hardwired to zero and never dumped
  localparam int FIRST_IDX = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - beat stream interface carrying index/data/mismatch
// Purpose: valid/ready stream of dump beats.
// Ports (signals):
//   out_valid    master->slave  beat available
//   out_ready    slave->master  sink accepts the beat
//   out_idx      master->slave  register index of the beat
//   out_data     master->slave  register content
//   out_mismatch master->slave  content differs from the expected word
interface regfile_dump_if
  import regfile_dump_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int WIDTH = WIDTH_DEF
);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [WIDTH-1:0] out_data;
  logic             out_mismatch;

  modport master (
    output out_valid, out_idx, out_data, out_mismatch,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_idx, out_data, out_mismatch,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks GPR 1..NREGS-1, compares against expected memory, streams beats
// Purpose: post-run register readout and pass/fail check.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   one-cycle dump request, honoured only in IDLE
//   rf_ra     out  GPR read address (0 outside READ)
//   rf_rd     in   GPR read data, combinational from rf_ra
//   exp_ra    out  expected-memory read address, mirrors rf_ra
//   exp_rd    in   expected word, combinational from exp_ra
//   out       -    beat stream (master side)
//   busy      out  dump in progress, through the DONE cycle
//   done      out  one-cycle pulse at the end of a dump
//   pass      out  last completed dump had no mismatch
//   fail_idx  out  lowest mismatching index of the last dump, 0 if none
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] rf_ra,
  input  logic [WIDTH-1:0] rf_rd,
  output logic [IDX_W-1:0] exp_ra,
  input  logic [WIDTH-1:0] exp_rd,
  regfile_dump_if.master   out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] fail_idx
);

  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(FIRST_IDX);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NREGS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mm_flag_q, mm_flag_d;
  logic [IDX_W-1:0] first_fail_q, first_fail_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_mm_q, out_mm_d;
  logic             pass_q, pass_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      mm_flag_q    <= 1'b0;
      first_fail_q <= '0;
      out_idx_q    <= '0;
      out_data_q   <= '0;
      out_mm_q     <= 1'b0;
      pass_q       <= 1'b0;
      fail_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mm_flag_q    <= mm_flag_d;
      first_fail_q <= first_fail_d;
      out_idx_q    <= out_idx_d;
      out_data_q   <= out_data_d;
      out_mm_q     <= out_mm_d;
      pass_q       <= pass_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mm_flag_d    = mm_flag_q;
    first_fail_d = first_fail_q;
    out_idx_d    = out_idx_q;
    out_data_d   = out_data_q;
    out_mm_d     = out_mm_q;
    pass_d       = pass_q;
    fail_idx_d   = fail_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d        = IDX_FIRST;
          mm_flag_d    = 1'b0;
          first_fail_d = '0;
          state_d      = ST_READ;
        end
      end
      ST_READ: begin
        out_idx_d  = idx_q;
        out_data_d = rf_rd;
        out_mm_d   = (rf_rd != exp_rd);
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (out.out_ready) begin
          // indices ascend, so the first recorded fail is the lowest one
          if (out_mm_q && !mm_flag_q) begin
            first_fail_d = idx_q;
            mm_flag_d    = 1'b1;
          end
          // terminal test before increment keeps idx from wrapping
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        pass_d     = !mm_flag_q;
        fail_idx_d = first_fail_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rf_ra         = '0;
    out.out_valid = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      ST_IDLE: busy          = 1'b0;
      ST_READ: rf_ra         = idx_q;
      ST_SEND: out.out_valid = 1'b1;
      ST_DONE: done          = 1'b1;
      default: busy          = 1'b0;
    endcase
  end

  assign exp_ra           = rf_ra;
  assign out.out_idx      = out_idx_q;
  assign out.out_data     = out_data_q;
  assign out.out_mismatch = out_mm_q;
  assign pass             = pass_q;
  assign fail_idx         = fail_idx_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - self-checking bench for regfile_dump
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  rf_ra, exp_ra, fail_idx;
  logic [31:0] rf_rd, exp_rd;
  logic        busy, done, pass;

  logic [31:0] rf_mem [32];
  logic [31:0] ex_mem [32];

  regfile_dump_if out_if ();

  assign rf_rd  = rf_mem[rf_ra];
  assign exp_rd = ex_mem[exp_ra];

  regfile_dump dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .rf_ra    (rf_ra),
    .rf_rd    (rf_rd),
    .exp_ra   (exp_ra),
    .exp_rd   (exp_rd),
    .out      (out_if),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_idx (fail_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        mm;
  } beat_t;

  beat_t       beats[$];
  logic        prev_v, prev_hs;
  logic [4:0]  prev_idx;
  logic [31:0] prev_data;

  // Beat collector plus hold/gap rules of the stream, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_v && !prev_hs) begin
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_idx !== prev_idx || out_if.out_data !== prev_data) begin
          errors++;
          $display("FAIL beat_hold got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                   out_if.out_valid, out_if.out_idx, out_if.out_data, prev_idx, prev_data);
        end
      end
      if (prev_hs) begin
        checks++;
        if (out_if.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_gap got out_valid=%b want 0 after handshake", out_if.out_valid);
        end
      end
      prev_v    = out_if.out_valid;
      prev_hs   = out_if.out_valid && out_if.out_ready;
      prev_idx  = out_if.out_idx;
      prev_data = out_if.out_data;
      if (prev_hs === 1'b1) beats.push_back('{out_if.out_idx, out_if.out_data, out_if.out_mismatch});
    end
  end

  // Reference result: pass when every dumped word equals its expected word,
  // fail index is the lowest differing register.
  function automatic void model(output logic p, output logic [4:0] f);
    p = 1'b1;
    f = 5'd0;
    for (int i = 31; i >= 1; i--) begin
      if (rf_mem[i] !== ex_mem[i]) begin
        p = 1'b0;
        f = 5'(i);
      end
    end
  endfunction

  // mode 0: ready high except stall_len cycles on stall_beat; mode 1: random ready.
  // start_beat>0 pulses start during SEND of that beat and again in the DONE cycle.
  task automatic run_dump(input int mode, input int stall_beat, input int stall_len,
                          input int start_beat, output int n_edges, output int first_v,
                          output int ndone, output logic pass_at_first);
    int stalled = 0;
    bit dup_sent = 0;
    beats.delete();
    ndone = 0;
    first_v = -1;
    n_edges = -1;
    pass_at_first = 1'bx;
    @(posedge clk); #1;
    start = 1'b1;
    out_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (first_v < 0 && out_if.out_valid === 1'b1) begin
        first_v = n;
        pass_at_first = pass;
      end
      if (mode == 1) begin
        out_if.out_ready = 1'($urandom_range(0, 1));
      end else if (out_if.out_valid === 1'b1 && out_if.out_idx == 5'(stall_beat) && stalled < stall_len) begin
        out_if.out_ready = 1'b0;
        stalled++;
      end else begin
        out_if.out_ready = 1'b1;
      end
      if (start_beat > 0 && !dup_sent && out_if.out_valid === 1'b1 && out_if.out_idx == 5'(start_beat)) begin
        start = 1'b1;
        dup_sent = 1;
      end
      if (done === 1'b1) begin
        ndone++;
        if (n_edges < 0) n_edges = n;
        if (start_beat > 0) start = 1'b1;
      end
      if (n_edges >= 0 && n >= n_edges + 4) break;
    end
    start = 1'b0;
    out_if.out_ready = 1'b1;
    checks++;
    if (n_edges < 0) begin
      errors++;
      $display("FAIL dump_timeout got no done want done within 400 cycles");
    end
  endtask

  task automatic test_reset();
    logic [56:0] all_out;
    rst_n = 1'b0;
    start = 1'b0;
    out_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    all_out = {rf_ra, exp_ra, out_if.out_valid, out_if.out_idx, out_if.out_data,
               out_if.out_mismatch, busy, done, pass, fail_idx};
    checks++;
    if (all_out !== 57'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", all_out);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, out_if.out_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_quiet got busy/valid/done %b want 000", {busy, out_if.out_valid, done});
    end
  endtask

  task automatic test_all_match();
    int ne, fv, nd;
    logic pf, mp;
    logic [4:0] mf;
    logic [31:0] a, b, t;
    a = 0; b = 1;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = a; ex_mem[i] = a;
      t = a + b; a = b; b = t;
    end
    ex_mem[0] = ~rf_mem[0];
    model(mp, mf);
    run_dump(0, 0, 0, 0, ne, fv, nd, pf);
    checks++;
    if (beats.size() !== 31) begin errors++; $display("FAIL match_count got %0d want 31", beats.size()); end
    for (int i = 0; i < beats.size() && i < 31; i++) begin
      checks++;
      if (beats[i].idx !== 5'(i + 1) || beats[i].data !== rf_mem[i + 1] || beats[i].mm !== (rf_mem[i + 1] != ex_mem[i + 1])) begin
        errors++;
        $display("FAIL match_beat%0d got idx %0d data %h mm %b want idx %0d data %h mm %b",
                 i, beats[i].idx, beats[i].data, beats[i].mm, i + 1, rf_mem[i + 1], rf_mem[i + 1] != ex_mem[i + 1]);
      end
    end
    checks++; if (fv !== 1) begin errors++; $display("FAIL first_valid got %0d want 1", fv); end
    checks++; if (ne !== 62) begin errors++; $display("FAIL match_latency got %0d want 62", ne); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL match_done_count got %0d want 1", nd); end
    checks++; if (pass !== mp || fail_idx !== mf) begin
      errors++; $display("FAIL match_result got pass %b fail_idx %0d want pass %b fail_idx %0d", pass, fail_idx, mp, mf);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL match_busy_end got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    int ne, fv, nd;
    logic pf, mp;
    logic [4:0] mf;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = $urandom; ex_mem[i] = rf_mem[i]; end
    rf_mem[5] = 32'h0000_0008;
    ex_mem[5] = 32'h0000_0009;
    ex_mem[20] = rf_mem[20] ^ 32'h8000_0000;
    model(mp, mf);
    run_dump(0, 0, 0, 0, ne, fv, nd, pf);
    checks++;
    if (beats.size() !== 31) begin errors++; $display("FAIL mism_count got %0d want 31", beats.size()); end
    for (int i = 0; i < beats.size() && i < 31; i++) begin
      checks++;
      if (beats[i].idx !== 5'(i + 1) || beats[i].data !== rf_mem[i + 1] || beats[i].mm !== (rf_mem[i + 1] != ex_mem[i + 1])) begin
        errors++;
        $display("FAIL mism_beat%0d got idx %0d data %h mm %b want idx %0d data %h mm %b",
                 i, beats[i].idx, beats[i].data, beats[i].mm, i + 1, rf_mem[i + 1], rf_mem[i + 1] != ex_mem[i + 1]);
      end
    end
    checks++; if (pass !== 1'b0 || fail_idx !== 5'd5 || mf !== 5'd5) begin
      errors++; $display("FAIL mism_result got pass %b fail_idx %0d want pass 0 fail_idx 5", pass, fail_idx);
    end
  endtask

  task automatic test_backpressure();
    int ne, fv, nd;
    logic pf;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = $urandom; ex_mem[i] = rf_mem[i]; end
    run_dump(0, 7, 3, 0, ne, fv, nd, pf);
    checks++;
    if (beats.size() !== 31) begin errors++; $display("FAIL bp_count got %0d want 31", beats.size()); end
    for (int i = 0; i < beats.size() && i < 31; i++) begin
      checks++;
      if (beats[i].idx !== 5'(i + 1) || beats[i].data !== rf_mem[i + 1]) begin
        errors++;
        $display("FAIL bp_beat%0d got idx %0d data %h want idx %0d data %h",
                 i, beats[i].idx, beats[i].data, i + 1, rf_mem[i + 1]);
      end
    end
    checks++; if (ne !== 65) begin errors++; $display("FAIL bp_latency got %0d want 65", ne); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL bp_pass got %b want 1", pass); end
  endtask

  task automatic test_start_ignored();
    int ne, fv, nd;
    logic pf;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = $urandom; ex_mem[i] = rf_mem[i]; end
    run_dump(0, 0, 0, 10, ne, fv, nd, pf);
    checks++;
    if (beats.size() !== 31) begin errors++; $display("FAIL ign_count got %0d want 31", beats.size()); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", nd); end
    checks++; if (ne !== 62) begin errors++; $display("FAIL ign_latency got %0d want 62", ne); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_end got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int ne, fv, nd;
    bit found = 0;
    logic pf, mp;
    logic [4:0] mf;
    logic [56:0] all_out;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = $urandom; ex_mem[i] = rf_mem[i]; end
    ex_mem[3] = ~rf_mem[3];
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (out_if.out_valid === 1'b1 && out_if.out_idx === 5'd12) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_reach got no beat 12 want beat 12 valid"); end
    #1 rst_n = 1'b0;
    #1;
    all_out = {rf_ra, exp_ra, out_if.out_valid, out_if.out_idx, out_if.out_data,
               out_if.out_mismatch, busy, done, pass, fail_idx};
    checks++;
    if (all_out !== 57'd0) begin errors++; $display("FAIL abort_outputs got %h want 0", all_out); end
    @(posedge clk); #1 rst_n = 1'b1;
    model(mp, mf);
    run_dump(0, 0, 0, 0, ne, fv, nd, pf);
    checks++;
    if (beats.size() !== 31) begin errors++; $display("FAIL abort_count got %0d want 31", beats.size()); end
    for (int i = 0; i < beats.size() && i < 31; i++) begin
      checks++;
      if (beats[i].idx !== 5'(i + 1) || beats[i].data !== rf_mem[i + 1] || beats[i].mm !== (rf_mem[i + 1] != ex_mem[i + 1])) begin
        errors++;
        $display("FAIL abort_beat%0d got idx %0d data %h mm %b want idx %0d data %h mm %b",
                 i, beats[i].idx, beats[i].data, beats[i].mm, i + 1, rf_mem[i + 1], rf_mem[i + 1] != ex_mem[i + 1]);
      end
    end
    checks++; if (pass !== mp || fail_idx !== mf) begin
      errors++; $display("FAIL abort_result got pass %b fail_idx %0d want pass %b fail_idx %0d", pass, fail_idx, mp, mf);
    end
  endtask

  task automatic test_cafebabe();
    int ne, fv, nd;
    logic pf;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = 32'hcafe_babe; ex_mem[i] = 32'hcafe_babe; end
    run_dump(0, 0, 0, 0, ne, fv, nd, pf);
    checks++; if (pass !== 1'b1 || fail_idx !== 5'd0) begin
      errors++; $display("FAIL cafe1_result got pass %b fail_idx %0d want pass 1 fail_idx 0", pass, fail_idx);
    end
    rf_mem[31] = 32'hcafe_babf;
    run_dump(0, 0, 0, 0, ne, fv, nd, pf);
    checks++; if (pf !== 1'b1) begin errors++; $display("FAIL cafe_pass_held got %b want 1", pf); end
    checks++; if (beats.size() !== 31 || beats[30].mm !== 1'b1) begin
      errors++; $display("FAIL cafe_last_beat got count %0d want 31 with beat 31 mismatching", beats.size());
    end
    checks++; if (pass !== 1'b0 || fail_idx !== 5'd31) begin
      errors++; $display("FAIL cafe2_result got pass %b fail_idx %0d want pass 0 fail_idx 31", pass, fail_idx);
    end
  endtask

  task automatic test_random_ready();
    int ne, fv, nd;
    logic pf, mp;
    logic [4:0] mf;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = $urandom;
      ex_mem[i] = ($urandom_range(0, 3) == 0) ? rf_mem[i] ^ (32'h1 << $urandom_range(0, 31)) : rf_mem[i];
    end
    model(mp, mf);
    run_dump(1, 0, 0, 0, ne, fv, nd, pf);
    checks++;
    if (beats.size() !== 31) begin errors++; $display("FAIL rnd_count got %0d want 31", beats.size()); end
    for (int i = 0; i < beats.size() && i < 31; i++) begin
      checks++;
      if (beats[i].idx !== 5'(i + 1) || beats[i].data !== rf_mem[i + 1] || beats[i].mm !== (rf_mem[i + 1] != ex_mem[i + 1])) begin
        errors++;
        $display("FAIL rnd_beat%0d got idx %0d data %h mm %b want idx %0d data %h mm %b",
                 i, beats[i].idx, beats[i].data, beats[i].mm, i + 1, rf_mem[i + 1], rf_mem[i + 1] != ex_mem[i + 1]);
      end
    end
    checks++; if (nd !== 1) begin errors++; $display("FAIL rnd_done_count got %0d want 1", nd); end
    checks++; if (pass !== mp || fail_idx !== mf) begin
      errors++; $display("FAIL rnd_result got pass %b fail_idx %0d want pass %b fail_idx %0d", pass, fail_idx, mp, mf);
    end
  endtask

  initial begin
    test_reset();
    test_all_match();
    test_mismatch();
    test_backpressure();
    test_start_ignored();
    test_reset_abort();
    test_cafebabe();
    test_random_ready();
    test_random_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
